// File: rtl/acc_pkg.sv
// Shared widths and FSM state codes for the accumulation engine.
// The accumulator is DATA_W+ADDR_W wide, so an unsigned sum of up to 63 words cannot overflow.
// Build option ACC_ENGINE_SAT_EN adds saturating accumulation and the acc_sat output.
package acc_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int ACC_W  = DATA_W + ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Adds a zero-extended word to the accumulator and returns the carry in the top bit.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [DATA_W-1:0] word);
    return {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, word};
  endfunction
endpackage

// File: rtl/acc_engine_if.sv
// Bundle of launch/config, memory-read and result signals for acc_engine.
// slave = engine side, master = launcher/memory/consumer side.
// acc_sat exists only when ACC_ENGINE_SAT_EN is defined.
interface acc_engine_if;
  import acc_pkg::*;

  logic              start;
  logic              accbypassA;
  logic [ADDR_W-1:0] startaddrA;
  logic [ADDR_W-1:0] datasizeA;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pass_data;
  logic              pass_valid;
  logic [ACC_W-1:0]  acc_sum;
  logic              sum_valid;
  logic              accdone;
  logic              busy;
`ifdef ACC_ENGINE_SAT_EN
  logic              acc_sat;

  modport slave (
    input  start, accbypassA, startaddrA, datasizeA, mem_rdata,
    output mem_rd, mem_addr, pass_data, pass_valid, acc_sum, sum_valid, accdone, busy, acc_sat
  );
  modport master (
    output start, accbypassA, startaddrA, datasizeA, mem_rdata,
    input  mem_rd, mem_addr, pass_data, pass_valid, acc_sum, sum_valid, accdone, busy, acc_sat
  );
`else
  modport slave (
    input  start, accbypassA, startaddrA, datasizeA, mem_rdata,
    output mem_rd, mem_addr, pass_data, pass_valid, acc_sum, sum_valid, accdone, busy
  );
  modport master (
    output start, accbypassA, startaddrA, datasizeA, mem_rdata,
    input  mem_rd, mem_addr, pass_data, pass_valid, acc_sum, sum_valid, accdone, busy
  );
`endif
endinterface

// File: rtl/acc_addr_gen.sv
// Read address generator: loads start address and word count, steps once per issued read.
// Address is registered; last_issue_o is combinational from the remaining count.
// No backpressure: issue_i advances unconditionally; address wraps modulo 2^ADDR_W.
module acc_addr_gen
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] startaddr_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic              issue_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_issue_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;

  // Next address / remaining count: load on launch, step on each issued read.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = startaddr_i;
      remain_d = count_i;
    end else if (issue_i) begin
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
    end
  end

  // Address and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o       = addr_q;
  assign last_issue_o = (remain_q == ADDR_W'(1));
endmodule

// File: rtl/acc_engine.sv
// Streams datasize words from memory and sums them, or passes them through in bypass mode.
// Latency: done pulse N+2 cycles after launch (1 cycle when N==0); launch only from IDLE.
// No backpressure: reads issue every cycle; start while busy is ignored. Option: ACC_ENGINE_SAT_EN.
module acc_engine
  import acc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  acc_engine_if.slave  bus
);
  logic [1:0]        state_q, state_d;
  logic              bypass_q;
  logic              rd_dly_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] pass_data_q;
  logic              pass_valid_q;
  logic [ACC_W:0]    acc_next;
  logic              launch;
  logic              reading;
  logic              last_issue;
  logic [ADDR_W-1:0] gen_addr;
`ifdef ACC_ENGINE_SAT_EN
  logic              sat_q;
`endif

  assign launch   = (state_q == ST_IDLE) && bus.start;
  assign reading  = (state_q == ST_READ);
  assign acc_next = acc_add(acc_q, bus.mem_rdata);

  acc_addr_gen u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (launch),
    .startaddr_i  (bus.startaddrA),
    .count_i      (bus.datasizeA),
    .issue_i      (reading),
    .addr_o       (gen_addr),
    .last_issue_o (last_issue)
  );

  // Control FSM: a zero-length request skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.datasizeA == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, config capture, read-return pipeline, accumulator and pass-through registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bypass_q     <= 1'b0;
      rd_dly_q     <= 1'b0;
      acc_q        <= '0;
      pass_data_q  <= '0;
      pass_valid_q <= 1'b0;
`ifdef ACC_ENGINE_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rd_dly_q     <= reading;
      pass_valid_q <= rd_dly_q && bypass_q;
      if (rd_dly_q && bypass_q) pass_data_q <= bus.mem_rdata;
      if (launch) begin
        bypass_q <= bus.accbypassA;
        acc_q    <= '0;
`ifdef ACC_ENGINE_SAT_EN
        sat_q    <= 1'b0;
`endif
      end else if (rd_dly_q && !bypass_q) begin
`ifdef ACC_ENGINE_SAT_EN
        // Once the sum overflows it pins at all-ones for the rest of the run.
        if (acc_next[ACC_W] || sat_q) begin
          acc_q <= '1;
          sat_q <= 1'b1;
        end else begin
          acc_q <= acc_next[ACC_W-1:0];
        end
`else
        acc_q <= acc_next[ACC_W-1:0];
`endif
      end
    end
  end

  assign bus.mem_rd     = reading;
  assign bus.mem_addr   = reading ? gen_addr : '0;
  assign bus.pass_data  = pass_data_q;
  assign bus.pass_valid = pass_valid_q;
  assign bus.acc_sum    = acc_q;
  assign bus.accdone    = (state_q == ST_DONE);
  assign bus.sum_valid  = (state_q == ST_DONE) && !bypass_q;
  assign bus.busy       = (state_q != ST_IDLE);
`ifdef ACC_ENGINE_SAT_EN
  assign bus.acc_sat    = sat_q && bus.sum_valid;
`endif
endmodule

// File: tb/tb_acc_engine.sv
// Randomized and directed bench for acc_engine against a per-run arithmetic reference.
// Expected traces are derived from launch offset d (cycles after the launch edge).
// Inputs are driven and outputs sampled on the falling edge.
module tb_acc_engine;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_engine_if bus ();

  acc_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [0:63];
  logic [ACC_W-1:0]  held_sum;
  int n_chk  = 0;
  int n_pass = 0;

  // Memory model: data valid the cycle after mem_rd, garbage otherwise.
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : DATA_W'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic scramble_cfg();
    bus.start      = 1'($urandom);
    bus.accbypassA = 1'($urandom);
    bus.startaddrA = ADDR_W'($urandom);
    bus.datasizeA  = ADDR_W'($urandom);
  endtask

  // One launch; abort=1 asserts reset during the second busy cycle.
  task automatic run_op(input logic byp, input int sa, input int n, input bit abort);
    longint      s;
    logic [ACC_W-1:0] exp_sum;
    bit          exp_sat;
    int          last;
    bit          exp_rd, exp_pv, stray;
    longint      max_sum;

    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.accdone, 0);
    chk("idle_rd", bus.mem_rd, 0);
    chk("idle_hold_sum", bus.acc_sum, held_sum);
    bus.start      = 1'b1;
    bus.accbypassA = byp;
    bus.startaddrA = ADDR_W'(sa);
    bus.datasizeA  = ADDR_W'(n);

    s = 0;
    for (int i = 0; i < n; i++) s += mem[(sa + i) % 64];
    max_sum = (longint'(1) << ACC_W) - 1;
    exp_sat = 1'b0;
`ifdef ACC_ENGINE_SAT_EN
    if (s > max_sum) begin
      s = max_sum;
      exp_sat = 1'b1;
    end
`endif
    exp_sum = s[ACC_W-1:0];
    if (byp) begin
      exp_sum = '0;
      exp_sat = 1'b0;
    end
    last = (n == 0) ? 1 : n + 2;

    for (int d = 1; d <= last; d++) begin
      @(negedge clk);
      exp_rd = (d <= n);
      exp_pv = byp && (d >= 3) && (d <= n + 2);
      chk("mem_rd", bus.mem_rd, exp_rd);
      if (exp_rd) chk("mem_addr", bus.mem_addr, (sa + d - 1) % 64);
      chk("pass_valid", bus.pass_valid, exp_pv);
      if (exp_pv) chk("pass_data", bus.pass_data, mem[(sa + d - 3) % 64]);
      chk("accdone", bus.accdone, d == last);
      chk("sum_valid", bus.sum_valid, (d == last) && !byp);
      chk("busy", bus.busy, 1);
      if (d == 1) chk("sum_cleared", bus.acc_sum, 0);
      if (d == last) begin
        chk("acc_sum", bus.acc_sum, exp_sum);
`ifdef ACC_ENGINE_SAT_EN
        chk("acc_sat", bus.acc_sat, exp_sat);
`endif
        held_sum = exp_sum;
      end
      if (abort && d == 2) begin
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.accdone, 0);
        chk("rst_sv", bus.sum_valid, 0);
        chk("rst_pv", bus.pass_valid, 0);
        chk("rst_pd", bus.pass_data, 0);
        chk("rst_sum", bus.acc_sum, 0);
        reset = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < n + 4; c++) begin
          @(negedge clk);
          if (bus.accdone || bus.mem_rd || bus.busy) stray = 1'b1;
        end
        chk("post_abort_quiet", stray, 0);
        held_sum = '0;
        return;
      end
      scramble_cfg();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.accbypassA = 1'b0;
    bus.startaddrA = '0;
    bus.datasizeA = '0;
    held_sum = '0;
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.accdone, 0);
    chk("reset_rd", bus.mem_rd, 0);
    chk("reset_pv", bus.pass_valid, 0);
    chk("reset_sum", bus.acc_sum, 0);
    reset = 1'b0;

    mem[5] = 16'd1; mem[6] = 16'd2; mem[7] = 16'd3; mem[8] = 16'd4;
    run_op(1'b0, 5, 4, 1'b0);
    mem[0] = 16'h000A; mem[1] = 16'h000B; mem[2] = 16'h000C;
    run_op(1'b1, 0, 3, 1'b0);
    run_op(1'b0, 62, 4, 1'b0);
    run_op(1'b1, 62, 4, 1'b0);
    run_op(1'b0, 17, 0, 1'b0);
    run_op(1'b1, 40, 0, 1'b0);
    run_op(1'b0, 3, 10, 1'b1);
    run_op(1'b0, 9, 1, 1'b0);

    for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
    run_op(1'b0, 0, 63, 1'b0);
    run_op(1'b0, 33, 63, 1'b0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
      run_op(1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
             ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
